// File: rtl/gb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_pkg
//  Description : Shared constants and state encoding for the OAM DMA engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_pkg;

    localparam logic [15:0] REG_DMA    = 16'hff46;
    localparam logic [15:0] OAM_BASE   = 16'hfe00;
    localparam int          OAM_LENGTH = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dma_state_t;

endpackage : gb_pkg
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma
//  Description : FF46 OAM DMA engine. A store to the DMA register copies
//                LENGTH bytes from page {src,8'h00} into sprite attribute
//                memory, one byte per cycle, through a one-cycle write stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma
    import gb_pkg::*;
#(
    parameter logic [15:0] REG_ADDR = gb_pkg::REG_DMA,
    parameter logic [15:0] OAM_BASE = gb_pkg::OAM_BASE,
    parameter int          LENGTH   = gb_pkg::OAM_LENGTH
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic [15:0] dma_address,
    output logic        dma_load,
    input  logic [7:0]  dma_indata,
    output logic [15:0] oam_address,
    output logic [7:0]  oam_data,
    output logic        oam_store,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t  state;
    dma_state_t  state_nxt;
    logic [7:0]  src;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  wr_idx;
    logic        wr_valid;
    logic        reg_store;
    logic        reg_load;

    assign reg_store = store && (address == REG_ADDR);
    assign reg_load  = load  && (address == REG_ADDR);

    // Pages E0-FF are the echo of C0-DF, so fold them back before addressing.
    assign page = (src >= 8'he0) ? (src - 8'h20) : src;

    // Source register: written by any CPU store to the DMA register.
    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            src <= 8'h00;
        end else if (reg_store) begin
            src <= indata;
        end
    end

    // Registered OR-bus readback; a same-cycle store is seen only next time.
    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            outdata <= 8'h00;
        end else begin
            outdata <= reg_load ? src : 8'h00;
        end
    end

    // State register.
    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a register store restarts from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (reg_store) begin
            state_nxt = RUN;
        end
    end

    // Read index: cleared on every start, advances once per read cycle.
    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            idx <= 8'h00;
        end else if (reg_store) begin
            idx <= 8'h00;
        end else if (state == RUN) begin
            idx <= idx + 8'h01;
        end
    end

    // Write stage follows the read stage by one cycle regardless of state,
    // so the byte read just before a restart is still written.
    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            wr_valid <= 1'b0;
            wr_idx   <= 8'h00;
        end else begin
            wr_valid <= dma_load;
            wr_idx   <= idx;
        end
    end

    // Output decode; every bus is held at zero while its strobe is low.
    always_comb begin
        dma_load    = (state == RUN);
        dma_address = dma_load ? {page, idx} : 16'h0000;
        oam_store   = wr_valid;
        oam_address = wr_valid ? (OAM_BASE + {8'h00, wr_idx}) : 16'h0000;
        oam_data    = wr_valid ? dma_indata : 8'h00;
        busy        = (state != IDLE);
    end

endmodule : oam_dma
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma
//  Description : Self-checking bench for oam_dma. A cycle-indexed schedule of
//                expected reads/readbacks is built from each CPU access and
//                compared against the DUT every cycle, plus directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma;

    localparam int MAXC = 8192;
    localparam int LEN  = 160;

    logic        clockgb;
    logic        resetn;
    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;
    logic [15:0] dma_address;
    logic        dma_load;
    logic [7:0]  dma_indata;
    logic [15:0] oam_address;
    logic [7:0]  oam_data;
    logic        oam_store;
    logic        busy;

    oam_dma dut (
        .clockgb     (clockgb),
        .resetn      (resetn),
        .address     (address),
        .indata      (indata),
        .outdata     (outdata),
        .load        (load),
        .store       (store),
        .dma_address (dma_address),
        .dma_load    (dma_load),
        .dma_indata  (dma_indata),
        .oam_address (oam_address),
        .oam_data    (oam_data),
        .oam_store   (oam_store),
        .busy        (busy)
    );

    initial clockgb = 1'b0;
    always #5 clockgb = ~clockgb;

    // Source memory and expectation schedule indexed by cycle number.
    logic [7:0]  mem    [0:65535];
    logic        rd_v   [0:MAXC-1];
    logic [15:0] rd_a   [0:MAXC-1];
    logic        rst_at [0:MAXC-1];
    logic [7:0]  out_e  [0:MAXC-1];

    int   cyc     = 0;
    int   checks  = 0;
    int   passes  = 0;
    int   fails   = 0;
    bit   started = 0;
    logic [7:0] src_m = 8'h00;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Source memory responder: data valid the cycle after a read strobe,
    // random junk otherwise.
    always @(posedge clockgb) begin
        if (dma_load === 1'b1) dma_indata <= mem[dma_address];
        else                   dma_indata <= 8'($urandom);
    end

    // Reference model: each CPU access in cycle c schedules its effects.
    always @(posedge clockgb) begin
        int c;
        logic [7:0] pg;
        c = cyc;
        if (resetn !== 1'b1) begin
            src_m     = 8'h00;
            rst_at[c] = 1'b1;
            for (int k = 1; k <= LEN + 2; k++) rd_v[c + k] = 1'b0;
            started = 1;
        end else begin
            if (load && address == 16'hff46) out_e[c + 1] = src_m;
            if (store && address == 16'hff46) begin
                src_m = indata;
                pg = (indata >= 8'he0) ? (indata - 8'h20) : indata;
                for (int k = 0; k < LEN; k++) begin
                    rd_v[c + 1 + k] = 1'b1;
                    rd_a[c + 1 + k] = {pg, 8'(k)};
                end
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison against the schedule.
    always @(negedge clockgb) begin
        int  n;
        bit  wr;
        n = cyc;
        if (started && n >= 1) begin
            wr = rd_v[n - 1] && !rst_at[n - 1];
            chk("dma_load",    dma_load,    rd_v[n]);
            chk("dma_address", dma_address, rd_v[n] ? rd_a[n] : 16'h0000);
            chk("oam_store",   oam_store,   wr);
            chk("oam_address", oam_address, wr ? (16'hfe00 + {8'h00, rd_a[n - 1][7:0]}) : 16'h0000);
            chk("oam_data",    oam_data,    wr ? mem[rd_a[n - 1]] : 8'h00);
            chk("busy",        busy,        rd_v[n] || wr);
            chk("outdata",     outdata,     out_e[n]);
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clockgb);
            #1;
        end
    endtask

    task automatic do_store(input logic [15:0] a, input logic [7:0] d, output int t);
        @(posedge clockgb); #1;
        address = a; indata = d; store = 1'b1;
        t = cyc;
        @(posedge clockgb); #1;
        store = 1'b0; address = 16'h0000;
    endtask

    initial begin
        int t;
        for (int i = 0; i < MAXC; i++) begin
            rd_v[i] = 1'b0; rd_a[i] = 16'h0000; rst_at[i] = 1'b0; out_e[i] = 8'h00;
        end
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < LEN; i++) mem[16'hc000 + i] = 8'(i) ^ 8'h5a;
        resetn = 1'b0; load = 1'b0; store = 1'b0; address = 16'h0000; indata = 8'h00;
        dma_indata = 8'h00;
        repeat (3) begin @(posedge clockgb); #1; end
        resetn = 1'b1;
        @(negedge clockgb);
        chk("reset_busy",    busy,    1'b0);
        chk("reset_outdata", outdata, 8'h00);

        // Basic copy from C000.
        do_store(16'hff46, 8'hc0, t);
        goto(t + 2);  @(negedge clockgb);
        chk("first_wr_addr", oam_address, 16'hfe00);
        chk("first_wr_data", oam_data, 8'h5a);
        goto(t + 161); @(negedge clockgb);
        chk("last_wr_addr", oam_address, 16'hfe9f);
        chk("last_wr_data", oam_data, 8'hc5);
        goto(t + 162); @(negedge clockgb);
        chk("idle_busy", busy, 1'b0);

        // Echo page and raw readback.
        do_store(16'hff46, 8'he1, t);
        address = 16'hff46; load = 1'b1;
        @(negedge clockgb);
        chk("echo_src_addr", dma_address, 16'hc100);
        @(posedge clockgb); #1;
        load = 1'b0; address = 16'h0000;
        @(negedge clockgb);
        chk("readback_e1", outdata, 8'he1);
        goto(t + 170);

        // Restart mid-copy.
        do_store(16'hff46, 8'hc0, t);
        goto(t + 50);
        address = 16'hff46; indata = 8'hd0; store = 1'b1;
        @(posedge clockgb); #1;
        store = 1'b0; address = 16'h0000;
        @(negedge clockgb);
        chk("restart_wr_addr", oam_address, 16'hfe31);
        chk("restart_wr_data", oam_data, 8'h6b);
        chk("restart_rd_addr", dma_address, 16'hd000);
        goto(t + 211); @(negedge clockgb);
        chk("restart_last_wr", oam_address, 16'hfe9f);
        goto(t + 212); @(negedge clockgb);
        chk("restart_idle", busy, 1'b0);

        // Reset mid-copy.
        do_store(16'hff46, 8'hc0, t);
        goto(t + 80);
        resetn = 1'b0;
        @(posedge clockgb); #1;
        resetn = 1'b1; address = 16'hff46; load = 1'b1;
        @(negedge clockgb);
        chk("abort_busy", busy, 1'b0);
        chk("abort_store", oam_store, 1'b0);
        @(posedge clockgb); #1;
        load = 1'b0; address = 16'h0000;
        @(negedge clockgb);
        chk("abort_src", outdata, 8'h00);
        goto(t + 250);

        // Neighbouring addresses never start or read back.
        do_store(16'hff45, 8'hc0, t);
        do_store(16'hff47, 8'hc0, t);
        address = 16'hff45; load = 1'b1;
        @(posedge clockgb); #1;
        address = 16'hff47;
        @(posedge clockgb); #1;
        load = 1'b0; address = 16'h0000;
        @(negedge clockgb);
        chk("neighbour_busy", busy, 1'b0);
        chk("neighbour_out", outdata, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(posedge clockgb); #1;
            resetn = ($urandom_range(0, 599) != 0);
            r = $urandom_range(0, 9);
            if (r < 3)       address = 16'hff46;
            else if (r == 3) address = 16'hff45;
            else if (r == 4) address = 16'hff47;
            else             address = 16'($urandom);
            indata = 8'($urandom);
            load   = ($urandom_range(0, 2) == 0);
            store  = ($urandom_range(0, 99) == 0);
        end
        @(posedge clockgb); #1;
        resetn = 1'b1; load = 1'b0; store = 1'b0; address = 16'h0000;
        repeat (200) begin @(posedge clockgb); #1; end
        @(negedge clockgb);
        chk("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_oam_dma
`default_nettype wire

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine for the FF46 register. A CPU store to FF46 copies LENGTH bytes from page `{value, 8'h00}` into sprite attribute memory at FE00–FE9F, one byte per cycle. It sits directly upstream of the PPU's sprite table: its OAM write port drives the same store path the sprite memory map uses. `busy` lets the bus arbiter block CPU access while a copy runs.

## Interface
- REG_ADDR, 16'hff46, CPU-visible DMA source register address
- OAM_BASE, 16'hfe00, first destination address
- LENGTH, 160, bytes per transfer (8-bit index, max 255)
- clockgb  in  1  system clock. One clock only; all state changes on its rising edge.
- resetn  in  1  reset; synchronous, active-low
- address  in  16  CPU bus address
- indata  in  8  CPU store data
- outdata  out  8  CPU read data; 0 when not addressed (OR-bus)
- load  in  1  CPU read strobe
- store  in  1  CPU write strobe
- dma_address  out  16  source read address
- dma_load  out  1  source read strobe
- dma_indata  in  8  source read data, valid the cycle after dma_load
- oam_address  out  16  destination address
- oam_data  out  8  destination data
- oam_store  out  1  destination write strobe
- busy  out  1  transfer in progress, including the drain cycle

## Operation
- Register `src`, 8 bits. Set by `store && address==REG_ADDR` to `indata`.
- Reading REG_ADDR returns `src`. Reads have no side effects.
- Effective source page:
  - If `src >= 8'hE0`, page is `src - 8'h20` (echo of C0–DF).
  - Otherwise page is `src`.
  - Register readback always returns the raw `src` value.
- States:
  - IDLE: waiting for a start.
  - RUN: issuing reads.
  - DRAIN: final write only.
- Transitions:
  - Any state: a store to REG_ADDR goes to RUN with `idx <= 0`.
  - RUN with `idx == LENGTH-1`: goes to DRAIN.
  - DRAIN: goes to IDLE.
- Read stage, in RUN:
  - `dma_load = 1`.
  - `dma_address = {page, idx}`; `idx` increments each cycle.
- Write stage, a one-cycle pipeline independent of the state:
  - `wr_valid` is the previous cycle's `dma_load`; `wr_idx` is the previous `idx`.
  - While `wr_valid`: `oam_store = 1`, `oam_address = OAM_BASE + wr_idx`, `oam_data = dma_indata`.
- Arithmetic:
  - `idx` is 8 bits.
  - `OAM_BASE + wr_idx` is a 16-bit add with no wrap.
  - Source address low byte is exactly `idx`, so the copy never crosses into the next page.
- Restart (store to REG_ADDR during RUN or DRAIN):
  - The byte already read is still written the following cycle.
  - The read index restarts at 0 with the new page.
  - No cycle carries two writes.
- `busy = (state != IDLE)`.
- The block performs no CPU-access blocking itself.

## Timing
- Reset (resetn low at an edge) clears the following at that edge:
  - `src = 8'h00`, state IDLE, `idx = 0`, `wr_valid = 0`.
  - All outputs 0: `outdata`, `dma_load`, `dma_address`, `oam_store`, `oam_address`, `oam_data`, `busy`.
- Reset mid-transfer aborts immediately. The in-flight write is dropped.
- CPU read: `load && address==REG_ADDR` in cycle T → `outdata = src` in cycle T+1 (registered). Otherwise `outdata` is 0 in T+1.
- A store in the same cycle as a load returns the old `src`.
- Start: store in cycle T, then:
  - T+1: first `dma_load`, index 0.
  - T+2: first `oam_store` to FE00.
  - T+160: last read, index 159.
  - T+161: last write, to FE9F, in DRAIN.
  - T+162: IDLE.
- `busy` is high T+1..T+161, i.e. 161 cycles.
- Throughput is 1 byte/cycle. End-to-end latency is LENGTH+1 cycles after the register write.

## Structure
- Shared package `gb_pkg` holds:
  - REG_DMA (16'hff46), OAM_BASE, OAM_LENGTH.
  - The 2-bit state encoding IDLE/RUN/DRAIN.
- Single module with no sub-module. Register decode is inline because the reset style differs from the existing mmap helpers.

## Test plan
- Fill C000–C09F with `i ^ 8'h5A`, store 8'hC0 to FF46 → 160 OAM writes FE00..FE9F with matching data; first `oam_store` at T+2, `busy` low at T+162.
- Store 8'hE1, then load FF46 → source addresses E100-range remapped to C100..C19F; readback 8'hE1 one cycle after the load.
- Restart: store 8'hC0, then store 8'hD0 at T+50 → write of index 49 (C0 data) still occurs at T+51; next read D000 at T+51; final write FE9F at T+211.
- Reset asserted at T+80 → next cycle every output 0 and `src` 8'h00; no further `oam_store`.
- Load/store at FF45 and FF47 → `outdata` 0, no transfer, `busy` stays 0.
